// File: rtl/toggle_event_decoder.sv
// Toggle-encoded event receiver: samples a toggle vector and presents the lanes that flipped as valid/ready event words.
// Optional macro TOGGLE_DEC_SYNC_EN adds a 2-stage input synchronizer (one extra cycle of latency).
module toggle_event_decoder #(
   parameter int SIZE  = 4,
   parameter int DELAY = 3,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [SIZE-1:0]  toggles_in,
   input  logic             en,
   output logic             evt_valid,
   output logic [SIZE-1:0]  evt_data,
   input  logic             evt_ready,
   output logic [SIZE-1:0]  ovf,
   input  logic             ovf_clr,
   output logic [CNT_W-1:0] xfer_cnt
);

   // state   | meaning
   // IDLE    | no event word held, evt_valid=0
   // HOLD    | event word held in evt_data, evt_valid=1
   typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

   state_t           state_q, state_d;
   logic [SIZE-1:0]  s_q, s_d;
   logic [SIZE-1:0]  ref_q, ref_d;
   logic [SIZE-1:0]  data_q, data_d;
   logic [SIZE-1:0]  ovf_q, ovf_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [SIZE-1:0]  pend;
   logic             load;
   logic             xfer;

   // DELAY only shifts register updates in delay-annotated simulation; updates here are zero-delay.
   if (DELAY < 0) begin : g_neg_delay
   end

`ifdef TOGGLE_DEC_SYNC_EN
   logic [SIZE-1:0] sync1_q, sync1_d;

   assign sync1_d = toggles_in;
   assign s_d     = sync1_q;

   always_ff @(posedge clk) begin
      if (reset) sync1_q <= '0;
      else       sync1_q <= sync1_d;
   end
`else
   assign s_d = toggles_in;
`endif

   always_comb begin
      pend    = s_q ^ ref_q;
      xfer    = (state_q == HOLD) && evt_ready;
      load    = en && (|pend) && ((state_q == IDLE) || evt_ready);
      state_d = state_q;
      ref_d   = ref_q;
      data_d  = data_q;
      cnt_d   = cnt_q + CNT_W'(xfer);
      if (load) begin
         state_d = HOLD;
         data_d  = pend;
         ref_d   = s_q;
      end else if (xfer) begin
         state_d = IDLE;
      end
      // A second flip on a still-pending lane cancels the first; a same-cycle load captures it instead.
      ovf_d = (ovf_clr ? '0 : ovf_q) | ((s_d ^ s_q) & pend & {SIZE{~load}});
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         s_q     <= '0;
         ref_q   <= '0;
         data_q  <= '0;
         ovf_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         ref_q   <= ref_d;
         data_q  <= data_d;
         ovf_q   <= ovf_d;
         cnt_q   <= cnt_d;
      end
   end

   assign evt_valid = (state_q == HOLD);
   assign evt_data  = data_q;
   assign ovf       = ovf_q;
   assign xfer_cnt  = cnt_q;

endmodule

// File: tb/tb_toggle_event_decoder.sv
// Bench for toggle_event_decoder: behavioural model checked every cycle, directed scenarios, and a wrap-around scoreboard run.
module tb_toggle_event_decoder;

`ifdef TOGGLE_DEC_SYNC_EN
   localparam bit SYNC = 1'b1;
   localparam int LAT  = 3;
`else
   localparam bit SYNC = 1'b0;
   localparam int LAT  = 2;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] toggles_in = 4'b0000;
   logic       en = 1'b0;
   logic       evt_valid;
   logic [3:0] evt_data;
   logic       evt_ready = 1'b0;
   logic [3:0] ovf;
   logic       ovf_clr = 1'b0;
   logic [7:0] xfer_cnt;

   int errors = 0;
   int checks = 0;

   toggle_event_decoder #(.SIZE(4), .DELAY(3), .CNT_W(8)) dut (
      .clk(clk), .reset(reset), .toggles_in(toggles_in), .en(en),
      .evt_valid(evt_valid), .evt_data(evt_data), .evt_ready(evt_ready),
      .ovf(ovf), .ovf_clr(ovf_clr), .xfer_cnt(xfer_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Model: the lanes seen so far vs the lanes already handed out decide what is pending.
   logic [3:0] m_sync, m_seen, m_given, m_data, m_ovf;
   logic       m_valid;
   int         m_cnt;
   bit         m_init = 0;

   always @(posedge clk) begin
      logic [3:0] nxt, pend, lost;
      logic       fire, take;
      if (reset) begin
         m_sync = 0; m_seen = 0; m_given = 0; m_data = 0; m_ovf = 0;
         m_valid = 0; m_cnt = 0; m_init = 1;
      end else begin
         nxt  = SYNC ? m_sync : toggles_in;
         pend = m_seen ^ m_given;
         fire = m_valid && evt_ready;
         take = en && (pend != 0) && (!m_valid || evt_ready);
         lost = take ? 4'b0000 : ((nxt ^ m_seen) & pend);
         m_ovf = (ovf_clr ? 4'b0000 : m_ovf) | lost;
         if (fire) m_cnt = (m_cnt + 1) % 256;
         if (take) begin
            m_data  = pend;
            m_given = m_seen;
            m_valid = 1;
         end else if (fire) begin
            m_valid = 0;
         end
         m_sync = toggles_in;
         m_seen = nxt;
      end
   end

   // Scoreboard for the streaming run: every driven change must come out once, in order.
   logic [3:0] sb_q[$];
   bit         sb_on = 0;
   bit         saw255 = 0;
   int         popped = 0;

   always @(negedge clk) begin
      if (m_init) begin
         chk("evt_valid", 32'(evt_valid), 32'(m_valid));
         chk("evt_data",  32'(evt_data),  32'(m_data));
         chk("ovf",       32'(ovf),       32'(m_ovf));
         chk("xfer_cnt",  32'(xfer_cnt),  32'(m_cnt));
      end
      if (sb_on) begin
         if (xfer_cnt == 8'd255) saw255 = 1;
         if (evt_valid && evt_ready) begin
            popped++;
            if (sb_q.size() == 0) chk("sb_extra_word", 32'(evt_data), 32'hFFFF);
            else chk("sb_word", 32'(evt_data), 32'(sb_q.pop_front()));
         end
      end
   end

   initial begin
      logic [3:0] t;
      tick(2);
      reset = 1'b0;
      chk("reset_valid", 32'(evt_valid), 0);
      chk("reset_cnt",   32'(xfer_cnt),  0);

      // first event and latency
      toggles_in = 4'b0001; en = 1'b1;
      tick(LAT - 1);
      chk("lat_not_yet", 32'(evt_valid), 0);
      tick(1);
      chk("lat_valid", 32'(evt_valid), 1);
      chk("lat_data",  32'(evt_data),  32'b0001);
      tick(5);
      chk("hold_valid", 32'(evt_valid), 1);
      chk("hold_data",  32'(evt_data),  32'b0001);
      evt_ready = 1'b1;
      tick(1);
      evt_ready = 1'b0;
      chk("xfer1_valid", 32'(evt_valid), 0);
      chk("xfer1_cnt",   32'(xfer_cnt),  1);

      // back-to-back
      toggles_in = 4'b0000;
      tick(LAT + 1);
      chk("b2b_first", 32'(evt_data), 32'b0001);
      toggles_in = 4'b0100;
      tick(LAT);
      evt_ready = 1'b1;
      tick(1);
      evt_ready = 1'b0;
      chk("b2b_valid", 32'(evt_valid), 1);
      chk("b2b_data",  32'(evt_data),  32'b0100);
      chk("b2b_cnt",   32'(xfer_cnt),  2);

      // double toggle of lane 3 while held
      toggles_in = 4'b1100;
      tick(3);
      toggles_in = 4'b0100;
      tick(LAT + 1);
      chk("ovf_set", 32'(ovf), 32'b1000);
      ovf_clr = 1'b1;
      tick(1);
      ovf_clr = 1'b0;
      chk("ovf_clr", 32'(ovf), 0);
      toggles_in = 4'b0110;
      tick(LAT);
      evt_ready = 1'b1;
      tick(1);
      chk("post_ovf_data", 32'(evt_data), 32'b0010);
      chk("post_ovf_cnt",  32'(xfer_cnt), 3);
      tick(1);
      evt_ready = 1'b0;
      chk("drain_valid", 32'(evt_valid), 0);
      chk("drain_cnt",   32'(xfer_cnt),  4);

      // en gating accumulates toggles into one word
      en = 1'b0;
      toggles_in = 4'b0101;
      tick(LAT + 3);
      chk("en_off_valid", 32'(evt_valid), 0);
      en = 1'b1;
      tick(1);
      chk("en_on_valid", 32'(evt_valid), 1);
      chk("en_on_data",  32'(evt_data),  32'b0011);
      evt_ready = 1'b1;
      tick(1);
      evt_ready = 1'b0;

      // reset mid-handshake
      toggles_in = 4'b0111;
      tick(LAT);
      chk("pre_rst_data", 32'(evt_data), 32'b0010);
      reset = 1'b1;
      tick(1);
      chk("rst_valid", 32'(evt_valid), 0);
      chk("rst_cnt",   32'(xfer_cnt),  0);
      chk("rst_ovf",   32'(ovf),       0);
      tick(1);
      reset = 1'b0;
      tick(LAT);
      chk("rel_valid", 32'(evt_valid), 1);
      chk("rel_data",  32'(evt_data),  32'b0111);

      // streaming run across the counter wrap
      reset = 1'b1;
      toggles_in = 4'b0000;
      tick(1);
      reset = 1'b0;
      tick(LAT + 2);
      chk("wrap_start_cnt", 32'(xfer_cnt), 0);
      sb_on = 1;
      evt_ready = 1'b1;
      t = 4'b0000;
      for (int i = 0; i < 256; i++) begin
         t = t ^ 4'((i % 15) + 1);
         toggles_in = t;
         sb_q.push_back(4'((i % 15) + 1));
         tick(1);
      end
      tick(LAT + 3);
      chk("wrap_cnt",     32'(xfer_cnt),   0);
      chk("wrap_popped",  32'(popped),     256);
      chk("wrap_sb_left", 32'(sb_q.size()), 0);
      chk("wrap_saw255",  32'(saw255),     1);
      chk("wrap_ovf",     32'(ovf),        0);
      sb_on = 0;
      evt_ready = 1'b0;
      tick(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
